// File: rtl/iir_pkg.sv
// Shared definitions for the shift-add first-order IIR and its inverse FIR.
// Both ends use SH_A/SH_B so the pole and its cancelling zero stay matched.
package iir_pkg;

   localparam int unsigned W    = 14;
   localparam int unsigned LAT  = 3;
   localparam int unsigned SH_A = 1;
   localparam int unsigned SH_B = 4;

   typedef logic signed [W:0]   data_t;
   typedef logic signed [W+1:0] hsum_t;
   typedef logic signed [W+2:0] diff_t;

   localparam data_t Y_MAX = {1'b0, {W{1'b1}}};
   localparam data_t Y_MIN = {1'b1, {W{1'b0}}};
   localparam diff_t D_MAX = {3'b000, {W{1'b1}}};
   localparam diff_t D_MIN = {3'b111, {W{1'b0}}};

   // Clamp a wide difference into the data range.
   function automatic data_t saturate(input diff_t d);
      data_t r;
      if (d > D_MAX) begin
         r = Y_MAX;
      end else if (d < D_MIN) begin
         r = Y_MIN;
      end else begin
         r = d[W:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/iir_inverse_fir_sat_clamp.sv
// Combinational clamp of the W+3-bit difference to W+1 bits, flagging
// whenever the value had to be limited.
module sat_clamp
   import iir_pkg::*;
(
   input  logic signed [W+2:0] d,
   output logic signed [W:0]   y,
   output logic                ovf
);

   assign y   = saturate(d);
   assign ovf = (d > D_MAX) || (d < D_MIN);

endmodule

// File: rtl/iir_inverse_fir.sv
// Three-stage shift-add FIR cancelling the 9/16 feedback pole of the
// forward IIR: e[n] = y[n] - (y[n-1]>>>1) - (y[n-1]>>>4), saturated.
module iir_inverse_fir
   import iir_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic signed [W:0] x_in,
   input  logic              sat_clr,
   output logic signed [W:0] y_out,
   output logic              y_valid,
   output logic              sat_flag
);

   data_t cur;
   data_t prev;
   data_t c2;
   hsum_t h;
   logic  v1;
   logic  v2;

   data_t prev_a_c;
   data_t prev_b_c;
   hsum_t h_c;
   diff_t d_c;
   data_t y_c;
   logic  ovf_c;

   assign prev_a_c = prev >>> SH_A;
   assign prev_b_c = prev >>> SH_B;
   assign h_c      = hsum_t'(prev_a_c) + hsum_t'(prev_b_c);
   assign d_c      = diff_t'(c2) - diff_t'(h);

   // History only advances on valid samples, so stalls never disturb it.
   always_ff @(posedge clk) begin
      if (reset) begin
         cur  <= '0;
         prev <= '0;
         v1   <= 1'b0;
      end else begin
         v1 <= in_valid;
         if (in_valid) begin
            cur  <= x_in;
            prev <= cur;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         h  <= '0;
         c2 <= '0;
         v2 <= 1'b0;
      end else begin
         h  <= h_c;
         c2 <= cur;
         v2 <= v1;
      end
   end

   sat_clamp u_sat_clamp (
      .d   (d_c),
      .y   (y_c),
      .ovf (ovf_c)
   );

   // y_out holds between results; consumers qualify with y_valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         y_out   <= '0;
         y_valid <= 1'b0;
      end else begin
         y_valid <= v2;
         if (v2) begin
            y_out <= y_c;
         end
      end
   end

   // Sticky overflow: a new clamp beats a simultaneous clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         sat_flag <= 1'b0;
      end else if (v2 && ovf_c) begin
         sat_flag <= 1'b1;
      end else if (sat_clr) begin
         sat_flag <= 1'b0;
      end
   end

endmodule

// File: tb/tb_iir_inverse_fir.sv
// Scoreboard bench for iir_inverse_fir: stimulus pushes expected results,
// an independent monitor pops and compares them whenever y_valid is seen.
module tb_iir_inverse_fir;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               in_valid = 1'b0;
   logic signed [14:0] x_in = '0;
   logic               sat_clr = 1'b0;
   logic signed [14:0] y_out;
   logic               y_valid;
   logic               sat_flag;

   typedef struct {
      int val;
      int tol;
      int cyc;
   } exp_t;

   exp_t sbq[$];
   exp_t e;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   ref_prev = 0;
   int   last_out = 0;

   iir_inverse_fir dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .x_in     (x_in),
      .sat_clr  (sat_clr),
      .y_out    (y_out),
      .y_valid  (y_valid),
      .sat_flag (sat_flag)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every valid output must match the oldest pending expectation.
   always @(negedge clk) begin
      if (y_valid) begin
         n_cmp++;
         if (sbq.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_valid: y_out=%0d at cycle %0d, expected no output", y_out, cyc);
         end else begin
            e = sbq.pop_front();
            if ((int'(y_out) - e.val > e.tol) || (e.val - int'(y_out) > e.tol) || (cyc != e.cyc)) begin
               n_bad++;
               $display("FAIL result: y_out=%0d at cycle %0d, expected %0d (tol %0d) at cycle %0d",
                        y_out, cyc, e.val, e.tol, e.cyc);
            end
            last_out = int'(y_out);
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int clamp(input int v);
      if (v > 16383) return 16383;
      if (v < -16384) return -16384;
      return v;
   endfunction

   // Reference: e = y - floor(prev/2) - floor(prev/16), clamped.
   function automatic int inv_model(input int x);
      return clamp(x - (ref_prev >>> 1) - (ref_prev >>> 4));
   endfunction

   task automatic send(input int x, input int exp, input int tol);
      in_valid = 1'b1;
      x_in     = 15'(x);
      sbq.push_back('{exp, tol, cyc + 3});
      ref_prev = x;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n, input logic clr);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b0;
         x_in     = 15'($urandom);
         sat_clr  = clr;
         @(posedge clk);
         #1;
      end
      sat_clr = 1'b0;
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (sbq.size() != 0 && k < 20) begin
         idle(1, 1'b0);
         k++;
      end
      if (sbq.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain_timeout: %0d results outstanding, expected 0", sbq.size());
         sbq.delete();
      end
      idle(2, 1'b0);
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      reset    = 1'b1;
      @(posedge clk);
      #1;
      reset    = 1'b0;
      sbq.delete();
      ref_prev = 0;
   endtask

   initial begin
      int x;
      int s;
      int iir_y;

      repeat (3) @(posedge clk);
      #1;
      check("reset_y_out", int'(y_out), 0);
      check("reset_y_valid", int'(y_valid), 0);
      check("reset_sat_flag", int'(sat_flag), 0);
      reset = 1'b0;

      // Impulse
      send(1024, 1024, 0);
      send(0, -576, 0);
      send(0, 0, 0);
      send(0, 0, 0);
      drain();
      check("hold_after_gap", int'(y_out), last_out);

      // Step
      do_reset();
      send(1600, 1600, 0);
      for (int i = 0; i < 6; i++) send(1600, 700, 0);
      drain();
      check("step_sat_flag", int'(sat_flag), 0);

      // Stall: history must survive idle cycles
      do_reset();
      send(1600, 1600, 0);
      idle(5, 1'b0);
      send(1600, 700, 0);
      drain();

      // Saturation
      do_reset();
      send(-16384, -16384, 0);
      send(16383, 16383, 0);
      drain();
      check("sat_flag_pos_clamp", int'(sat_flag), 1);
      send(16383, 7169, 0);
      send(-16384, -16384, 0);
      drain();
      idle(1, 1'b1);
      check("sat_clr_clears", int'(sat_flag), 0);
      send(16383, 16383, 0);
      idle(1, 1'b0);
      idle(1, 1'b1);
      check("set_beats_clr", int'(sat_flag), 1);
      drain();

      // Reset with two samples in flight
      do_reset();
      send(1000, 0, 0);
      send(2000, 0, 0);
      do_reset();
      send(1024, 1024, 0);
      drain();

      // Random full-range stream with random gaps
      do_reset();
      for (int i = 0; i < 200; i++) begin
         x = int'($urandom_range(0, 32767)) - 16384;
         send(x, inv_model(x), 0);
         if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)), 1'b0);
      end
      drain();

      // Cascade: forward IIR then this block recovers x + 3/4 x
      do_reset();
      iir_y = 0;
      for (int i = 0; i < 300; i++) begin
         x     = int'($urandom_range(0, 4000)) - 2000;
         s     = x + (x >>> 1) + (x >>> 2);
         iir_y = s + (iir_y >>> 1) + (iir_y >>> 4);
         send(iir_y, s, 2);
      end
      drain();
      check("cascade_sat_flag", int'(sat_flag), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
